// File: rtl/updown_sweep_ctrl_if.sv
// Start/busy/done handshake and counter outputs of updown_sweep_ctrl.
// The pause signal exists only when SWEEP_PAUSE_EN is defined.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH    = 3,
  parameter int SWEEPS_W = 4
);
  logic                start;
  logic [WIDTH-1:0]    lo;
  logic [WIDTH-1:0]    hi;
  logic [SWEEPS_W-1:0] n_sweeps;
`ifdef SWEEP_PAUSE_EN
  logic                pause;
`endif
  logic [WIDTH-1:0]    count;
  logic                mode;
  logic                busy;
  logic                done;
  logic                err;
  logic [SWEEPS_W-1:0] sweeps_left;

`ifdef SWEEP_PAUSE_EN
  modport master (
    output start, lo, hi, n_sweeps, pause,
    input  count, mode, busy, done, err, sweeps_left
  );
  modport slave (
    input  start, lo, hi, n_sweeps, pause,
    output count, mode, busy, done, err, sweeps_left
  );
`else
  modport master (
    output start, lo, hi, n_sweeps,
    input  count, mode, busy, done, err, sweeps_left
  );
  modport slave (
    input  start, lo, hi, n_sweeps,
    output count, mode, busy, done, err, sweeps_left
  );
`endif
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer: counts lo..hi..lo for n round trips per start.
// Optional freeze input is enabled by defining SWEEP_PAUSE_EN.
module updown_sweep_ctrl #(
  parameter int WIDTH    = 3,
  parameter int SWEEPS_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  updown_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]    ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SWEEPS_W-1:0] ONE_S = {{(SWEEPS_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_nxt_s;
  logic [WIDTH-1:0]    count_r, count_nxt_s;
  logic [WIDTH-1:0]    lo_r, lo_nxt_s, hi_r, hi_nxt_s;
  logic [SWEEPS_W-1:0] sweeps_r, sweeps_nxt_s;
  logic                done_r, done_nxt_s, err_r, err_nxt_s;
  logic                req_ok_s, accept_s, reject_s, hold_s, at_hi_s, at_lo_s, last_s;

  assign req_ok_s = (bus.lo < bus.hi) && (bus.n_sweeps != {SWEEPS_W{1'b0}});
  assign accept_s = (state_r == IDLE) && bus.start && req_ok_s;
  assign reject_s = (state_r == IDLE) && bus.start && !req_ok_s;
  assign at_hi_s  = (count_r == hi_r);
  assign at_lo_s  = (count_r == lo_r);
  assign last_s   = (sweeps_r == ONE_S);
`ifdef SWEEP_PAUSE_EN
  // Freeze only matters while a job runs; IDLE ignores it.
  assign hold_s   = bus.pause && (state_r != IDLE);
`else
  assign hold_s   = 1'b0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      sweeps_r <= {SWEEPS_W{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      count_r  <= count_nxt_s;
      lo_r     <= lo_nxt_s;
      hi_r     <= hi_nxt_s;
      sweeps_r <= sweeps_nxt_s;
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = UP; else state_nxt_s = IDLE;
      UP:      if (!hold_s && at_hi_s) state_nxt_s = DOWN; else state_nxt_s = UP;
      DOWN: begin
        if (hold_s || !at_lo_s) state_nxt_s = DOWN;
        else if (last_s)        state_nxt_s = IDLE;
        else                    state_nxt_s = UP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of count, sweep counter, bound latches and pulses.
  always_comb begin
    count_nxt_s  = count_r;
    sweeps_nxt_s = sweeps_r;
    lo_nxt_s     = lo_r;
    hi_nxt_s     = hi_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          count_nxt_s  = bus.lo;
          sweeps_nxt_s = bus.n_sweeps;
          lo_nxt_s     = bus.lo;
          hi_nxt_s     = bus.hi;
        end else if (reject_s) begin
          err_nxt_s    = 1'b1;
        end else begin
          count_nxt_s  = count_r;
        end
      end
      UP: begin
        if (hold_s)       count_nxt_s = count_r;
        else if (at_hi_s) count_nxt_s = hi_r - ONE_W;
        else              count_nxt_s = count_r + ONE_W;
      end
      DOWN: begin
        if (hold_s) begin
          count_nxt_s  = count_r;
        end else if (!at_lo_s) begin
          count_nxt_s  = count_r - ONE_W;
        end else if (last_s) begin
          sweeps_nxt_s = {SWEEPS_W{1'b0}};
          done_nxt_s   = 1'b1;
        end else begin
          sweeps_nxt_s = sweeps_r - ONE_S;
          count_nxt_s  = lo_r + ONE_W;
        end
      end
      default: begin
        count_nxt_s  = {WIDTH{1'b0}};
        sweeps_nxt_s = {SWEEPS_W{1'b0}};
      end
    endcase
  end

  assign bus.count       = count_r;
  assign bus.mode        = (state_r == DOWN);
  assign bus.busy        = (state_r != IDLE);
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.sweeps_left = sweeps_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: directed plan plus random traffic
// against a queue-based reference of the expected per-cycle outputs.
module tb_updown_sweep_ctrl;
  localparam int WIDTH    = 3;
  localparam int SWEEPS_W = 4;

  typedef struct {
    int c;
    int m;
    int s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH), .SWEEPS_W(SWEEPS_W)) bus ();
  updown_sweep_ctrl #(.WIDTH(WIDTH), .SWEEPS_W(SWEEPS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   idle_count = 0;
  bit   exp_done   = 1'b0;
  bit   exp_err    = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;
  int   busy_cycles;
  int   done_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected outputs of a whole job, one entry per busy cycle.
  task automatic build(input int l, input int h, input int n);
    q.delete();
    for (int s = n; s >= 1; s--) begin
      for (int c = (s == n) ? l : l + 1; c <= h; c++) q.push_back(exp_t'{c, 0, s});
      for (int c = h - 1; c >= l; c--) q.push_back(exp_t'{c, 1, s});
    end
  endtask

  task automatic step(input bit r, input bit st, input int l, input int h, input int n, input bit p);
    bit   hold_m;
    exp_t head;
    int   ec, em, eb, es;
    rst          = r;
    bus.start    = st;
    bus.lo       = l[WIDTH-1:0];
    bus.hi       = h[WIDTH-1:0];
    bus.n_sweeps = n[SWEEPS_W-1:0];
`ifdef SWEEP_PAUSE_EN
    bus.pause    = p;
    hold_m       = p;
`else
    hold_m       = p & 1'b0;
`endif
    @(posedge clk);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (r) begin
      q.delete();
      idle_count = 0;
    end else if (q.size() > 0) begin
      if (!hold_m) begin
        head = q.pop_front();
        if (q.size() == 0) begin
          exp_done   = 1'b1;
          idle_count = head.c;
        end
      end
    end else if (st) begin
      if ((l % 8) < (h % 8) && (n % 16) != 0) build(l % 8, h % 8, n % 16);
      else exp_err = 1'b1;
    end
    #1;
    if (q.size() > 0) begin
      ec = q[0].c; em = q[0].m; eb = 1; es = q[0].s;
    end else begin
      ec = idle_count; em = 0; eb = 0; es = 0;
    end
    chk("count", bus.count, ec);
    chk("mode", bus.mode, em);
    chk("busy", bus.busy, eb);
    chk("sweeps_left", bus.sweeps_left, es);
    chk("done", bus.done, exp_done);
    chk("err", bus.err, exp_err);
    busy_cycles += int'(bus.busy);
    done_pulses += int'(bus.done);
  endtask

  // Idle-input cycles until the reference job finishes, bounded.
  task automatic run_out(input int budget, input bit junk_start);
    int k = 0;
    while (q.size() > 0 && k < budget) begin
      step(1'b0, junk_start, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), 1'b0);
      k++;
    end
    if (q.size() > 0) chk("run_out_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    busy_cycles = 0;
    done_pulses = 0;
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 3, 1, 1'b0);

    busy_cycles = 0; done_pulses = 0;
    step(1'b0, 1'b1, 1, 3, 1, 1'b0);
    run_out(50, 1'b0);
    chk("single_busy_len", busy_cycles, 5);
    chk("single_done_cnt", done_pulses, 1);

    busy_cycles = 0; done_pulses = 0;
    step(1'b0, 1'b1, 0, 7, 2, 1'b0);
    run_out(100, 1'b0);
    chk("full_busy_len", busy_cycles, 29);
    chk("full_done_cnt", done_pulses, 1);

    busy_cycles = 0;
    step(1'b0, 1'b1, 5, 5, 3, 1'b0);
    step(1'b0, 1'b0, 2, 4, 0, 1'b0);
    step(1'b0, 1'b1, 2, 4, 0, 1'b0);
    step(1'b0, 1'b0, 6, 1, 2, 1'b0);
    chk("reject_busy", busy_cycles, 0);

    done_pulses = 0;
    step(1'b0, 1'b1, 0, 7, 1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 7, 1, 1'b0);
    chk("mode_before_rst", bus.mode, 1);
    step(1'b1, 1'b0, 0, 7, 1, 1'b0);
    step(1'b0, 1'b0, 0, 7, 1, 1'b0);
    chk("rst_no_done", done_pulses, 0);

    busy_cycles = 0;
    step(1'b0, 1'b1, 2, 5, 2, 1'b0);
    run_out(100, 1'b1);
    chk("ignored_start_len", busy_cycles, 13);

    step(1'b0, 1'b1, 1, 2, 1, 1'b0);
    run_out(20, 1'b0);
    busy_cycles = 0;
    step(1'b0, 1'b1, 3, 6, 1, 1'b0);
    chk("b2b_busy", bus.busy, 1);
    run_out(50, 1'b0);
    chk("b2b_busy_len", busy_cycles, 7);

`ifdef SWEEP_PAUSE_EN
    busy_cycles = 0;
    step(1'b0, 1'b1, 0, 4, 1, 1'b1);
    step(1'b0, 1'b0, 0, 4, 1, 1'b0);
    step(1'b0, 1'b0, 0, 4, 1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 4, 1, 1'b1);
    chk("pause_hold_count", bus.count, 2);
    step(1'b0, 1'b0, 0, 4, 1, 1'b0);
    chk("pause_resume", bus.count, 3);
    run_out(50, 1'b0);
    chk("pause_busy_len", busy_cycles, 12);
`endif

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
